// File: rtl/calc1_pkg.sv
// Shared encodings, FSM state type and helper functions for the four-port calculator.
package calc1_pkg;

  localparam int DATA_W = 32;
  localparam int NPORTS = 4;

  localparam logic [3:0] CMD_NONE = 4'd0;
  localparam logic [3:0] CMD_ADD  = 4'd1;
  localparam logic [3:0] CMD_SUB  = 4'd2;
  localparam logic [3:0] CMD_SHL  = 4'd5;
  localparam logic [3:0] CMD_SHR  = 4'd6;

  localparam logic [1:0] RESP_NONE   = 2'd0;
  localparam logic [1:0] RESP_OK     = 2'd1;
  localparam logic [1:0] RESP_ERR    = 2'd2;
  localparam logic [1:0] RESP_INTERR = 2'd3;

  typedef enum logic [1:0] {ST_IDLE, ST_OP2, ST_WAIT, ST_RESP} state_t;

  function automatic logic is_addsub(input logic [3:0] c);
    return (c == CMD_ADD) || (c == CMD_SUB);
  endfunction

  function automatic logic is_shift(input logic [3:0] c);
    return (c == CMD_SHL) || (c == CMD_SHR);
  endfunction

  // Round-robin pick: the first requester at or after ptr wins.
  function automatic logic [NPORTS-1:0] rr_grant(input logic [NPORTS-1:0] req,
                                                 input logic [1:0] ptr);
    logic [NPORTS-1:0] g;
    logic [1:0] idx;
    g = '0;
    for (int k = NPORTS - 1; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) g = NPORTS'(1) << idx;
    end
    return g;
  endfunction

  function automatic logic [1:0] onehot_idx(input logic [NPORTS-1:0] oh);
    logic [1:0] idx;
    idx = '0;
    for (int k = 0; k < NPORTS; k++) begin
      if (oh[k]) idx = 2'(k);
    end
    return idx;
  endfunction

endpackage

// File: rtl/calc1_port_ctrl.sv
// One requester port: command FSM, operand latches and registered response outputs.
module calc1_port_ctrl
  import calc1_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        cmd_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              grant,
  input  logic [1:0]        exec_resp,
  input  logic [DATA_W-1:0] exec_data,
  output logic              req_addsub,
  output logic              req_shift,
  output logic [3:0]        cmd,
  output logic [DATA_W-1:0] op1,
  output logic [DATA_W-1:0] op2,
  output logic [1:0]        resp_out,
  output logic [DATA_W-1:0] data_out
);

  state_t state, state_nxt;
  logic   load;
  logic   valid_cmd;

  assign valid_cmd = is_addsub(cmd) || is_shift(cmd);

  // State register; reset discards any in-flight command.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Operand capture: cmd/op1 while idle, op2 in the following cycle.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE) begin
      cmd <= cmd_in;
      op1 <= data_in;
    end
    if (state == ST_OP2) op2 <= data_in;
  end

  // Next state, unit requests and response load strobe.
  always_comb begin
    state_nxt  = state;
    req_addsub = 1'b0;
    req_shift  = 1'b0;
    load       = 1'b0;
    case (state)
      ST_IDLE: if (cmd_in != CMD_NONE) state_nxt = ST_OP2;
      ST_OP2:  state_nxt = ST_WAIT;
      ST_WAIT: begin
        req_addsub = is_addsub(cmd);
        req_shift  = is_shift(cmd);
        // Invalid commands skip arbitration and answer immediately.
        if (!valid_cmd || grant) begin
          load      = 1'b1;
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Response registers: hold a result for exactly one cycle, zero otherwise.
  always_ff @(posedge clk) begin
    if (rst || !load) begin
      resp_out <= RESP_NONE;
      data_out <= '0;
    end else if (valid_cmd) begin
      resp_out <= exec_resp;
      data_out <= exec_data;
    end else begin
      resp_out <= RESP_ERR;
      data_out <= '0;
    end
  end

endmodule

// File: rtl/calc1_top.sv
// Four-port calculator: per-port controllers sharing one add/sub and one shift unit,
// each unit behind its own round-robin arbiter.
module calc1_top
  import calc1_pkg::*;
(
  input  logic        c_clk,
  input  logic [1:7]  reset,
  input  logic [0:3]  req1_cmd_in,
  input  logic [0:31] req1_data_in,
  input  logic [0:3]  req2_cmd_in,
  input  logic [0:31] req2_data_in,
  input  logic [0:3]  req3_cmd_in,
  input  logic [0:31] req3_data_in,
  input  logic [0:3]  req4_cmd_in,
  input  logic [0:31] req4_data_in,
  output logic [0:1]  out_resp1,
  output logic [0:31] out_data1,
  output logic [0:1]  out_resp2,
  output logic [0:31] out_data2,
  output logic [0:1]  out_resp3,
  output logic [0:31] out_data3,
  output logic [0:1]  out_resp4,
  output logic [0:31] out_data4
);

  // Returns {resp, data} for add (carry out is an error) or unsigned subtract
  // (borrow is an error).
  function automatic logic [DATA_W+1:0] addsub_exec(input logic [3:0] c,
                                                    input logic [DATA_W-1:0] a,
                                                    input logic [DATA_W-1:0] b);
    logic [DATA_W:0] sum;
    logic [DATA_W+1:0] res;
    sum = {1'b0, a} + {1'b0, b};
    if (c == CMD_SUB) begin
      if (b > a) res = {RESP_ERR, {DATA_W{1'b0}}};
      else       res = {RESP_OK, a - b};
    end else begin
      if (sum[DATA_W]) res = {RESP_ERR, {DATA_W{1'b0}}};
      else             res = {RESP_OK, sum[DATA_W-1:0]};
    end
    return res;
  endfunction

  // Logical shift by the low five bits of the second operand.
  function automatic logic [DATA_W-1:0] shift_exec(input logic [3:0] c,
                                                   input logic [DATA_W-1:0] a,
                                                   input logic [4:0] amt);
    if (c == CMD_SHL) return a << amt;
    else              return a >> amt;
  endfunction

  logic              rst;
  logic [3:0]        cmd_in   [NPORTS];
  logic [DATA_W-1:0] dat_in   [NPORTS];
  logic [3:0]        cmd_q    [NPORTS];
  logic [DATA_W-1:0] op1_q    [NPORTS];
  logic [DATA_W-1:0] op2_q    [NPORTS];
  logic [1:0]        resp_q   [NPORTS];
  logic [DATA_W-1:0] data_q   [NPORTS];
  logic [1:0]        exec_resp[NPORTS];
  logic [DATA_W-1:0] exec_data[NPORTS];
  logic [NPORTS-1:0] req_as, req_sh, gnt_as, gnt_sh, grant;
  logic [1:0]        ptr_as, ptr_sh, idx_as, idx_sh;
  logic [1:0]        as_resp;
  logic [DATA_W-1:0] as_data, sh_data;

  assign rst = |reset;

  assign cmd_in[0] = req1_cmd_in;  assign dat_in[0] = req1_data_in;
  assign cmd_in[1] = req2_cmd_in;  assign dat_in[1] = req2_data_in;
  assign cmd_in[2] = req3_cmd_in;  assign dat_in[2] = req3_data_in;
  assign cmd_in[3] = req4_cmd_in;  assign dat_in[3] = req4_data_in;

  assign out_resp1 = resp_q[0];  assign out_data1 = data_q[0];
  assign out_resp2 = resp_q[1];  assign out_data2 = data_q[1];
  assign out_resp3 = resp_q[2];  assign out_data3 = data_q[2];
  assign out_resp4 = resp_q[3];  assign out_data4 = data_q[3];

  for (genvar g = 0; g < NPORTS; g++) begin : g_port
    calc1_port_ctrl u_port (
      .clk       (c_clk),
      .rst       (rst),
      .cmd_in    (cmd_in[g]),
      .data_in   (dat_in[g]),
      .grant     (grant[g]),
      .exec_resp (exec_resp[g]),
      .exec_data (exec_data[g]),
      .req_addsub(req_as[g]),
      .req_shift (req_sh[g]),
      .cmd       (cmd_q[g]),
      .op1       (op1_q[g]),
      .op2       (op2_q[g]),
      .resp_out  (resp_q[g]),
      .data_out  (data_q[g])
    );
    assign grant[g]     = gnt_as[g] | gnt_sh[g];
    assign exec_resp[g] = gnt_sh[g] ? RESP_OK : as_resp;
    assign exec_data[g] = gnt_sh[g] ? sh_data : as_data;
  end

  assign gnt_as = rr_grant(req_as, ptr_as);
  assign gnt_sh = rr_grant(req_sh, ptr_sh);
  assign idx_as = onehot_idx(gnt_as);
  assign idx_sh = onehot_idx(gnt_sh);

  // Round-robin pointers move just past whichever port was served.
  always_ff @(posedge c_clk) begin
    if (rst) begin
      ptr_as <= 2'd0;
      ptr_sh <= 2'd0;
    end else begin
      if (|gnt_as) ptr_as <= idx_as + 2'd1;
      if (|gnt_sh) ptr_sh <= idx_sh + 2'd1;
    end
  end

  // Shared units operate on the operands of the granted port.
  always_comb begin
    {as_resp, as_data} = addsub_exec(cmd_q[idx_as], op1_q[idx_as], op2_q[idx_as]);
    sh_data            = shift_exec(cmd_q[idx_sh], op1_q[idx_sh], op2_q[idx_sh][4:0]);
  end

endmodule

// File: tb/tb_calc1_top.sv
// Randomized and directed scoreboard bench for calc1_top.
module tb_calc1_top;
  import calc1_pkg::*;

  typedef struct {
    logic [1:0]  resp;
    logic [31:0] data;
    int          issue;
    int          lat;   // 0: any latency in 3..6 accepted
  } exp_t;

  logic        c_clk = 1'b0;
  logic [1:7]  rst_d;
  logic [0:3]  cmd_d  [4];
  logic [0:31] dat_d  [4];
  logic [0:1]  resp_o [4];
  logic [0:31] data_o [4];

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_on = 1'b0;
  exp_t sbq[4][$];

  logic [3:0]  st_cmd [4];
  logic [31:0] st_a   [4];
  logic [31:0] st_b   [4];
  int          st_lat [4];

  always #5 c_clk = ~c_clk;
  always @(posedge c_clk) cyc <= cyc + 1;

  calc1_top dut (
    .c_clk(c_clk), .reset(rst_d),
    .req1_cmd_in(cmd_d[0]), .req1_data_in(dat_d[0]),
    .req2_cmd_in(cmd_d[1]), .req2_data_in(dat_d[1]),
    .req3_cmd_in(cmd_d[2]), .req3_data_in(dat_d[2]),
    .req4_cmd_in(cmd_d[3]), .req4_data_in(dat_d[3]),
    .out_resp1(resp_o[0]), .out_data1(data_o[0]),
    .out_resp2(resp_o[1]), .out_data2(data_o[1]),
    .out_resp3(resp_o[2]), .out_data3(data_o[2]),
    .out_resp4(resp_o[3]), .out_data4(data_o[3])
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Reference behaviour from the calculator rules, using wide integer arithmetic.
  function automatic void ref_model(input logic [3:0] c, input logic [31:0] a,
                                    input logic [31:0] b, output logic [1:0] r,
                                    output logic [31:0] d);
    longint s;
    int     amt;
    amt = int'(b % 32);
    r = 2'd2;
    d = 32'd0;
    case (c)
      4'd1: begin
        s = longint'(a) + longint'(b);
        if (s <= 64'hFFFF_FFFF) begin r = 2'd1; d = 32'(s); end
      end
      4'd2: if (a >= b) begin r = 2'd1; d = a - b; end
      4'd5: begin r = 2'd1; d = a << amt; end
      4'd6: begin r = 2'd1; d = a >> amt; end
      default: ;
    endcase
  endfunction

  // Monitor: pops the scoreboard whenever a port presents a response.
  always @(negedge c_clk) begin
    exp_t e;
    int   l;
    if (mon_on) begin
      for (int i = 0; i < 4; i++) begin
        if (resp_o[i] !== 2'd0) begin
          if (sbq[i].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_resp_p%0d: got resp %0d data %h, expected no response",
                     i + 1, resp_o[i], data_o[i]);
          end else begin
            e = sbq[i].pop_front();
            l = cyc - e.issue;
            chk($sformatf("resp_p%0d", i + 1), 32'(resp_o[i]), 32'(e.resp));
            chk($sformatf("data_p%0d", i + 1), data_o[i], e.data);
            if (e.lat != 0) begin
              chk($sformatf("latency_p%0d", i + 1), 32'(l), 32'(e.lat));
            end else begin
              checks++;
              if (l < 3 || l > 6) begin
                errors++;
                $display("FAIL latency_range_p%0d: got %0d, expected 3..6", i + 1, l);
              end
            end
          end
        end else begin
          chk($sformatf("idle_data_p%0d", i + 1), data_o[i], 32'd0);
        end
      end
    end
  end

  task automatic drain();
    int n;
    n = 0;
    while ((sbq[0].size() + sbq[1].size() + sbq[2].size() + sbq[3].size()) != 0 && n < 40) begin
      @(posedge c_clk);
      n++;
    end
    checks++;
    if (n >= 40) begin
      errors++;
      $display("FAIL response_timeout: got %0d pending, expected 0",
               sbq[0].size() + sbq[1].size() + sbq[2].size() + sbq[3].size());
      for (int i = 0; i < 4; i++) sbq[i].delete();
    end
    @(posedge c_clk);
  endtask

  // Issue staged commands on the masked ports in the same cycle, then wait for all responses.
  task automatic fire(input logic [3:0] m);
    @(posedge c_clk); #1;
    for (int i = 0; i < 4; i++) begin
      if (m[i]) begin
        exp_t        e;
        logic [1:0]  r;
        logic [31:0] d;
        ref_model(st_cmd[i], st_a[i], st_b[i], r, d);
        e.resp = r; e.data = d; e.issue = cyc; e.lat = st_lat[i];
        sbq[i].push_back(e);
        cmd_d[i] = st_cmd[i];
        dat_d[i] = st_a[i];
      end
    end
    @(posedge c_clk); #1;
    for (int i = 0; i < 4; i++) begin
      if (m[i]) begin
        cmd_d[i] = 4'd0;
        dat_d[i] = st_b[i];
      end
    end
    @(posedge c_clk); #1;
    for (int i = 0; i < 4; i++) dat_d[i] = 32'd0;
    drain();
  endtask

  task automatic one(input int p, input logic [3:0] c, input logic [31:0] a,
                     input logic [31:0] b);
    st_cmd[p] = c; st_a[p] = a; st_b[p] = b; st_lat[p] = 3;
    fire(4'(1 << p));
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_resp_p%0d", tag, i + 1), 32'(resp_o[i]), 32'd0);
      chk($sformatf("%s_data_p%0d", tag, i + 1), data_o[i], 32'd0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] cl [10];
    logic [3:0] m;
    cl = '{4'd1, 4'd2, 4'd5, 4'd6, 4'd1, 4'd2, 4'd3, 4'd4, 4'd7, 4'd15};
    rst_d = 7'h7F;
    for (int i = 0; i < 4; i++) begin cmd_d[i] = 4'd0; dat_d[i] = 32'd0; end
    repeat (3) @(posedge c_clk);
    #1;
    check_all_zero("reset_state");
    rst_d = 7'd0;
    mon_on = 1'b1;

    // Four-way add contention straight after reset: port 1 first, then 2, 3, 4.
    for (int i = 0; i < 4; i++) begin
      st_cmd[i] = CMD_ADD; st_a[i] = 32'(i + 1); st_b[i] = 32'(i + 1); st_lat[i] = 3 + i;
    end
    fire(4'hF);

    // Port 1 add/sub cases.
    one(0, CMD_ADD, 32'h0000_0001, 32'h01FF_FFFF);
    one(0, CMD_ADD, 32'h1FFF_FFFF, 32'h1FFF_FFFF);
    one(0, CMD_ADD, 32'd0, 32'd0);
    one(0, CMD_ADD, 32'hFFFF_FFFF, 32'd1);
    one(0, CMD_SUB, 32'd1, 32'd15);
    one(0, CMD_SUB, 32'd15, 32'd1);
    one(0, CMD_SUB, 32'd77, 32'd77);
    // Invalid commands, each followed by a normal add.
    one(0, 4'd3, 32'd1, 32'd1);
    one(0, 4'd4, 32'd1, 32'd1);
    one(0, CMD_ADD, 32'd2, 32'd3);

    // Port 2 shifts.
    one(1, CMD_SHL, 32'h0000_0001, 32'd4);
    one(1, CMD_SHR, 32'h8000_0000, 32'h0000_0021);
    one(1, CMD_SHL, 32'hFFFF_FFFF, 32'd31);

    // Add and shift on different units in the same cycle: no contention.
    st_cmd[0] = CMD_ADD; st_a[0] = 32'd100; st_b[0] = 32'd23; st_lat[0] = 3;
    st_cmd[1] = CMD_SHR; st_a[1] = 32'hF000_0000; st_b[1] = 32'd8; st_lat[1] = 3;
    fire(4'b0011);

    // Reset (bit 1 only) during the operand-2 cycle of a pending add.
    @(posedge c_clk); #1;
    cmd_d[0] = CMD_ADD; dat_d[0] = 32'd5;
    @(posedge c_clk); #1;
    cmd_d[0] = 4'd0; dat_d[0] = 32'd6;
    rst_d = 7'b1000000;
    cmd_d[1] = CMD_ADD; dat_d[1] = 32'd9;
    @(posedge c_clk); #1;
    check_all_zero("in_reset_a");
    @(posedge c_clk); #1;
    check_all_zero("in_reset_b");
    rst_d = 7'd0;
    cmd_d[1] = 4'd0;
    for (int i = 0; i < 4; i++) dat_d[i] = 32'd0;
    repeat (8) @(posedge c_clk);
    one(0, CMD_ADD, 32'd5, 32'd6);

    // Randomized traffic on random port subsets.
    for (int r = 0; r < 40; r++) begin
      m = 4'($urandom_range(1, 15));
      for (int i = 0; i < 4; i++) begin
        st_cmd[i] = cl[$urandom_range(0, 9)];
        st_lat[i] = 0;
        case ($urandom_range(0, 3))
          0: st_a[i] = 32'hFFFF_FFFF;
          1: st_a[i] = 32'($urandom_range(0, 20));
          default: st_a[i] = $urandom;
        endcase
        case ($urandom_range(0, 3))
          0: st_b[i] = 32'hFFFF_FFFF;
          1: st_b[i] = 32'($urandom_range(0, 40));
          default: st_b[i] = $urandom;
        endcase
      end
      fire(m);
    end

    repeat (4) @(posedge c_clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
